// File: rtl/core_ecc_dec.sv
// Two-stage Hamming(7,4) receive decoder with valid/ready flow control.
// Define CORE_ECC_DEC_ERR_CNT_EN to build the corrected-word counter.
module core_ecc_dec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_corrected,
    output logic [2:0]       out_syndrome,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    logic        s1_v;
    logic [10:0] s1_word;
    logic        adv;
    logic        accept;
    logic [2:0]  syn;
    logic [10:0] flip;
    logic [10:0] fixed;

    assign adv      = !out_valid || out_ready;
    assign in_ready = rst_n && (!s1_v || adv);
    assign accept   = in_valid && in_ready;

    assign syn[0] = s1_word[4] ^ s1_word[6] ^ s1_word[8] ^ s1_word[10];
    assign syn[1] = s1_word[5] ^ s1_word[6] ^ s1_word[9] ^ s1_word[10];
    assign syn[2] = s1_word[7] ^ s1_word[8] ^ s1_word[9] ^ s1_word[10];

    // Syndrome value k points at word bit 3+k.
    always_comb begin
        flip = '0;
        for (int i = 1; i < 8; i++) begin
            if (syn == 3'(i)) flip[i+3] = 1'b1;
        end
    end

    assign fixed = s1_word ^ flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_word <= '0;
        end else begin
            if (accept) begin
                s1_v    <= 1'b1;
                s1_word <= in_data;
            end else if (adv) begin
                s1_v    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_corrected <= 1'b0;
            out_syndrome  <= '0;
        end else if (adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_data      <= {fixed[10], fixed[9], fixed[8],
                                  fixed[6], fixed[3:0]};
                out_corrected <= (syn != 3'd0);
                out_syndrome  <= syn;
            end
        end
    end

`ifdef CORE_ECC_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (out_valid && out_ready && out_corrected
                     && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign corr_cnt = cnt;
`else
    logic unused_clr;

    assign unused_clr = clr_cnt;
    assign corr_cnt   = '0;
`endif

endmodule
